// File: rtl/fir_stream_ctrl_if.sv
// fir_stream_ctrl_if: bus-side and FIR-side signal bundle for the FIR stream sequencer.
interface fir_stream_ctrl_if #(
  parameter int IW        = 12,
  parameter int OW        = 31,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
);
  logic                       wr_valid;
  logic [IW-1:0]              wr_data;
  logic                       wr_ready;
  logic                       rd_req;
  logic [OW-1:0]              rd_data;
  logic                       rd_valid;
  logic                       cfg_enable;
  logic                       cfg_flush;
  logic                       fir_ce;
  logic [IW-1:0]              fir_sample;
  logic [OW-1:0]              fir_result;
  logic [$clog2(IN_DEPTH):0]  in_count;
  logic [$clog2(OUT_DEPTH):0] out_count;
  logic                       busy;
  logic                       flush_done;
  logic                       overflow;
  logic                       underflow;
  logic                       err_clr;
  logic                       irq;
  modport master (
    output wr_valid, wr_data, rd_req, cfg_enable, cfg_flush, fir_result, err_clr,
    input  wr_ready, rd_data, rd_valid, fir_ce, fir_sample, in_count, out_count,
           busy, flush_done, overflow, underflow, irq
  );
  modport slave (
    input  wr_valid, wr_data, rd_req, cfg_enable, cfg_flush, fir_result, err_clr,
    output wr_ready, rd_data, rd_valid, fir_ce, fir_sample, in_count, out_count,
           busy, flush_done, overflow, underflow, irq
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequences buffered samples into a FIR datapath one fir_ce step at a time,
// discards warm-up results, queues valid results and drains the pipeline with zeros on flush.
module fir_stream_ctrl #(
  parameter int IW          = 12,
  parameter int OW          = 31,
  parameter int IN_DEPTH    = 8,
  parameter int OUT_DEPTH   = 8,
  parameter int PRIME_STEPS = 5,
  parameter int IRQ_THRESH  = 4
) (
  input logic         HCLK,
  input logic         HRESETn,
  fir_stream_ctrl_if.slave bus
);
  localparam int IA = $clog2(IN_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);
  localparam int PW = $clog2(PRIME_STEPS + 1);
  localparam logic [PW-1:0] PRIME_MAX  = PW'(PRIME_STEPS);
  localparam logic [PW-1:0] FLUSH_LAST = PW'(PRIME_STEPS - 1);
  localparam logic [OA:0]   THRESH     = (OA+1)'(IRQ_THRESH);
  typedef enum logic [2:0] {IDLE, STEP, CAPTURE, FLUSH_STEP, FLUSH_CAP} state_t;
  state_t        r_state, w_next;
  logic [IW-1:0] r_in_mem  [IN_DEPTH];
  logic [OW-1:0] r_out_mem [OUT_DEPTH];
  logic [IA-1:0] r_in_wp, r_in_rp;
  logic [IA:0]   r_in_cnt;
  logic [OA-1:0] r_out_wp, r_out_rp;
  logic [OA:0]   r_out_cnt;
  logic [PW-1:0] r_prime, r_fcnt;
  logic          r_pend, r_ovf, r_udf;
  logic          w_in_full, w_in_empty, w_out_full, w_out_empty, w_primed;
  logic          w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic          w_ovf_ev, w_udf_ev, w_ce, w_done;
  // Depths are powers of two, so the count MSB alone flags full.
  assign w_in_full   = r_in_cnt[IA];
  assign w_in_empty  = r_in_cnt == '0;
  assign w_out_full  = r_out_cnt[OA];
  assign w_out_empty = r_out_cnt == '0;
  assign w_primed    = r_prime == PRIME_MAX;
  assign w_in_push   = bus.wr_valid && (!w_in_full || w_in_pop);
  assign w_ovf_ev    = bus.wr_valid && w_in_full && !w_in_pop;
  assign w_out_pop   = bus.rd_req && !w_out_empty;
  assign w_udf_ev    = bus.rd_req && w_out_empty;
  always_comb begin
    w_next     = r_state;
    w_ce       = 1'b0;
    w_in_pop   = 1'b0;
    w_out_push = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_done = r_pend && r_prime == '0;
        w_next = (r_pend && r_prime != '0) ? FLUSH_STEP :
                 (!r_pend && bus.cfg_enable && !w_in_empty && (!w_primed || !w_out_full)) ? STEP : IDLE;
      end
      STEP: begin
        w_ce     = 1'b1;
        w_in_pop = 1'b1;
        w_next   = CAPTURE;
      end
      CAPTURE: begin
        w_out_push = w_primed;
        w_next     = IDLE;
      end
      FLUSH_STEP: begin
        w_ce   = !w_out_full;
        w_next = w_out_full ? FLUSH_STEP : FLUSH_CAP;
      end
      FLUSH_CAP: begin
        w_out_push = 1'b1;
        w_done     = r_fcnt == FLUSH_LAST;
        w_next     = w_done ? IDLE : FLUSH_STEP;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= IDLE;
      r_in_wp   <= '0;
      r_in_rp   <= '0;
      r_in_cnt  <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      r_prime   <= '0;
      r_fcnt    <= '0;
      r_pend    <= 1'b0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_in_wp   <= w_in_push ? r_in_wp + IA'(1) : r_in_wp;
      r_in_rp   <= w_in_pop ? r_in_rp + IA'(1) : r_in_rp;
      r_in_cnt  <= r_in_cnt + (IA+1)'(w_in_push) - (IA+1)'(w_in_pop);
      r_out_wp  <= w_out_push ? r_out_wp + OA'(1) : r_out_wp;
      r_out_rp  <= w_out_pop ? r_out_rp + OA'(1) : r_out_rp;
      r_out_cnt <= r_out_cnt + (OA+1)'(w_out_push) - (OA+1)'(w_out_pop);
      r_prime   <= (r_state == CAPTURE && !w_primed) ? r_prime + PW'(1) :
                   (r_state == FLUSH_CAP && w_done) ? '0 : r_prime;
      r_fcnt    <= (r_state == FLUSH_CAP) ? (w_done ? '0 : r_fcnt + PW'(1)) : r_fcnt;
      r_pend    <= w_done ? 1'b0 : (r_pend | bus.cfg_flush);
      r_ovf     <= w_ovf_ev | (r_ovf & ~bus.err_clr);
      r_udf     <= w_udf_ev | (r_udf & ~bus.err_clr);
    end
  end
  // Storage needs no reset: reads are gated by the occupancy counters.
  always_ff @(posedge HCLK) begin
    if (w_in_push) r_in_mem[r_in_wp] <= bus.wr_data;
    if (w_out_push) r_out_mem[r_out_wp] <= bus.fir_result;
  end
  assign bus.wr_ready   = !w_in_full;
  assign bus.rd_data    = w_out_empty ? '0 : r_out_mem[r_out_rp];
  assign bus.rd_valid   = !w_out_empty;
  assign bus.fir_ce     = w_ce;
  assign bus.fir_sample = (r_state == STEP) ? r_in_mem[r_in_rp] : '0;
  assign bus.in_count   = r_in_cnt;
  assign bus.out_count  = r_out_cnt;
  assign bus.busy       = (r_state != IDLE) || r_pend;
  assign bus.flush_done = w_done;
  assign bus.overflow   = r_ovf;
  assign bus.underflow  = r_udf;
  assign bus.irq        = (r_out_cnt >= THRESH) || r_ovf;
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: scoreboard bench driving fir_stream_ctrl against a small 2-tap FIR
// (y = 3*x[n] + x[n-1]) that, like the real datapath, is never reset.
module tb_fir_stream_ctrl;
  localparam int IW = 12, OW = 31, IND = 8, OUTD = 8, PS = 2, TH = 4;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  fir_stream_ctrl_if #(.IW(IW), .OW(OW), .IN_DEPTH(IND), .OUT_DEPTH(OUTD)) bus ();
  fir_stream_ctrl #(.IW(IW), .OW(OW), .IN_DEPTH(IND), .OUT_DEPTH(OUTD),
                    .PRIME_STEPS(PS), .IRQ_THRESH(TH)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
  always #5 HCLK = ~HCLK;
  logic [OW-1:0] fir_res = '0;
  logic [IW-1:0] fir_x1 = '0;
  always @(posedge HCLK) if (bus.fir_ce) begin
    fir_x1  <= bus.fir_sample;
    fir_res <= OW'(bus.fir_sample) * OW'(3) + OW'(fir_x1);
  end
  assign bus.fir_result = fir_res;
  int cyc = 0, ce_cnt = 0, ce_nz = 0, done_cnt = 0, last_ce = -100, min_gap = 1000;
  always @(negedge HCLK) begin
    cyc++;
    if (bus.flush_done === 1'b1) done_cnt++;
    if (bus.fir_ce === 1'b1) begin
      ce_cnt++;
      if (bus.fir_sample !== '0) ce_nz++;
      if (cyc - last_ce < min_gap) min_gap = cyc - last_ce;
      last_ce = cyc;
    end
  end
  int n_vec = 0, n_err = 0;
  logic [OW-1:0] q[$];
  logic [IW-1:0] sw_prev = '0;
  int sw_prime = 0;
  task automatic model_step(input logic [IW-1:0] x);
    logic [OW-1:0] e;
    e = OW'(x) * OW'(3) + OW'(sw_prev);
    sw_prev = x;
    if (sw_prime == PS) q.push_back(e);
    else sw_prime++;
  endtask
  task automatic model_flush();
    if (sw_prime > 0) begin
      repeat (PS) begin
        q.push_back(OW'(sw_prev));
        sw_prev = '0;
      end
    end
    sw_prime = 0;
  endtask
  task automatic push(input logic [IW-1:0] x, input bit mdl);
    bus.wr_valid = 1'b1;
    bus.wr_data  = x;
    if (mdl) model_step(x);
    @(negedge HCLK);
    bus.wr_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while ((bus.in_count !== '0 || bus.busy !== 1'b0) && k < 400) begin
      @(negedge HCLK);
      k++;
    end
    n_vec++;
    if (k >= 400) begin n_err++; $display("FAIL %s_idle_timeout got %0d cycles limit 400", tag, k); end
  endtask
  task automatic drain(input string tag);
    int k = 0;
    logic [OW-1:0] e;
    while (q.size() > 0 && k < 600) begin
      if (bus.rd_valid === 1'b1) begin
        e = q.pop_front();
        n_vec++;
        if (bus.rd_data !== e) begin n_err++; $display("FAIL %s_rd_data got %0h exp %0h", tag, bus.rd_data, e); end
        bus.rd_req = 1'b1;
      end else bus.rd_req = 1'b0;
      @(negedge HCLK);
      k++;
    end
    bus.rd_req = 1'b0;
    n_vec++;
    if (k >= 600) begin n_err++; $display("FAIL %s_drain_timeout got %0d left exp 0", tag, q.size()); end
  endtask
  task automatic test_reset();
    #1;
    n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready got %b exp 1", bus.wr_ready); end
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_ready2 got %b exp 1", bus.wr_ready); end
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid got %b exp 0", bus.rd_valid); end
    n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL rst_rd_data got %0h exp 0", bus.rd_data); end
    n_vec++; if (bus.in_count !== '0) begin n_err++; $display("FAIL rst_in_count got %0d exp 0", bus.in_count); end
    n_vec++; if (bus.out_count !== '0) begin n_err++; $display("FAIL rst_out_count got %0d exp 0", bus.out_count); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.fir_ce !== 1'b0) begin n_err++; $display("FAIL rst_fir_ce got %b exp 0", bus.fir_ce); end
    n_vec++; if ({bus.irq, bus.overflow, bus.underflow, bus.flush_done} !== 4'b0) begin
      n_err++; $display("FAIL rst_flags got %b exp 0000", {bus.irq, bus.overflow, bus.underflow, bus.flush_done}); end
  endtask
  task automatic test_stream();
    int base = ce_cnt;
    bus.cfg_enable = 1'b1;
    foreach (q[i]) q.delete(i);
    for (int i = 0; i < 5; i++) push(IW'(100 + 37 * i), 1'b1);
    wait_idle("stream");
    n_vec++; if (ce_cnt - base !== 5) begin n_err++; $display("FAIL stream_ce_count got %0d exp 5", ce_cnt - base); end
    n_vec++; if (min_gap < 3) begin n_err++; $display("FAIL stream_ce_spacing got %0d exp >=3", min_gap); end
    n_vec++; if (bus.out_count !== 4'd3) begin n_err++; $display("FAIL stream_out_count got %0d exp 3", bus.out_count); end
  endtask
  task automatic test_flush();
    int base = ce_cnt, nz = ce_nz, dn = done_cnt;
    bus.cfg_flush = 1'b1;
    model_flush();
    @(negedge HCLK);
    bus.cfg_flush = 1'b0;
    wait_idle("flush");
    n_vec++; if (ce_cnt - base !== PS) begin n_err++; $display("FAIL flush_ce_count got %0d exp %0d", ce_cnt - base, PS); end
    n_vec++; if (ce_nz !== nz) begin n_err++; $display("FAIL flush_zero_sample got %0d nonzero exp 0", ce_nz - nz); end
    n_vec++; if (bus.out_count !== 4'd5) begin n_err++; $display("FAIL flush_out_count got %0d exp 5", bus.out_count); end
    n_vec++; if (done_cnt - dn !== 1) begin n_err++; $display("FAIL flush_done_pulses got %0d exp 1", done_cnt - dn); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL flush_irq got %b exp 1", bus.irq); end
    drain("flush");
  endtask
  task automatic test_overflow();
    bus.cfg_enable = 1'b0;
    for (int i = 0; i < 9; i++) push(IW'(500 + 11 * i), i < 8);
    n_vec++; if (bus.in_count !== 4'd8) begin n_err++; $display("FAIL ovf_in_count got %0d exp 8", bus.in_count); end
    n_vec++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL ovf_wr_ready got %b exp 0", bus.wr_ready); end
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
    n_vec++; if (bus.irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq got %b exp 1", bus.irq); end
    bus.err_clr = 1'b1;
    @(negedge HCLK);
    bus.err_clr = 1'b0;
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
    n_vec++; if (bus.irq !== 1'b0) begin n_err++; $display("FAIL ovf_irq_clear got %b exp 0", bus.irq); end
  endtask
  task automatic test_full_stall();
    int base;
    logic [OW-1:0] e;
    bus.cfg_enable = 1'b1;
    wait_idle("stall_pre");
    n_vec++; if (bus.out_count !== 4'd6) begin n_err++; $display("FAIL stall_out_pre got %0d exp 6", bus.out_count); end
    base = ce_cnt;
    for (int i = 0; i < 5; i++) push(IW'(900 + 123 * i), 1'b1);
    repeat (30) @(negedge HCLK);
    n_vec++; if (bus.out_count !== 4'd8) begin n_err++; $display("FAIL stall_out_full got %0d exp 8", bus.out_count); end
    n_vec++; if (bus.in_count !== 4'd3) begin n_err++; $display("FAIL stall_in_count got %0d exp 3", bus.in_count); end
    n_vec++; if (ce_cnt - base !== 2) begin n_err++; $display("FAIL stall_ce_count got %0d exp 2", ce_cnt - base); end
    base = ce_cnt;
    repeat (20) @(negedge HCLK);
    n_vec++; if (ce_cnt - base !== 0) begin n_err++; $display("FAIL stall_hold got %0d steps exp 0", ce_cnt - base); end
    e = q.pop_front();
    n_vec++; if (bus.rd_data !== e) begin n_err++; $display("FAIL stall_rd_data got %0h exp %0h", bus.rd_data, e); end
    bus.rd_req = 1'b1;
    @(negedge HCLK);
    bus.rd_req = 1'b0;
    base = ce_cnt;
    repeat (20) @(negedge HCLK);
    n_vec++; if (ce_cnt - base !== 1) begin n_err++; $display("FAIL stall_resume got %0d steps exp 1", ce_cnt - base); end
    n_vec++; if (bus.in_count !== 4'd2) begin n_err++; $display("FAIL stall_in_after got %0d exp 2", bus.in_count); end
    n_vec++; if (bus.out_count !== 4'd8) begin n_err++; $display("FAIL stall_out_after got %0d exp 8", bus.out_count); end
    drain("stall");
    wait_idle("stall_post");
    n_vec++; if (bus.out_count !== '0) begin n_err++; $display("FAIL stall_out_end got %0d exp 0", bus.out_count); end
  endtask
  task automatic test_underflow();
    bus.rd_req = 1'b1;
    @(negedge HCLK);
    bus.rd_req = 1'b0;
    n_vec++; if (bus.rd_data !== '0) begin n_err++; $display("FAIL udf_rd_data got %0h exp 0", bus.rd_data); end
    n_vec++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_rd_valid got %b exp 0", bus.rd_valid); end
    n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b exp 1", bus.underflow); end
    n_vec++; if (bus.out_count !== '0) begin n_err++; $display("FAIL udf_out_count got %0d exp 0", bus.out_count); end
    bus.err_clr = 1'b1;
    @(negedge HCLK);
    bus.err_clr = 1'b0;
    n_vec++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear got %b exp 0", bus.underflow); end
  endtask
  task automatic test_reset_mid();
    int k = 0;
    push(IW'(1234), 1'b1);
    push(IW'(777), 1'b0);
    while (bus.fir_ce !== 1'b1 && k < 20) begin @(negedge HCLK); k++; end
    n_vec++; if (k >= 20) begin n_err++; $display("FAIL mid_ce_timeout got %0d cycles limit 20", k); end
    @(posedge HCLK);
    #1;
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_capture got %b exp 1", bus.busy); end
    HRESETn = 1'b0;
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
    n_vec++; if (bus.in_count !== '0) begin n_err++; $display("FAIL mid_in_count got %0d exp 0", bus.in_count); end
    n_vec++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_wr_ready got %b exp 1", bus.wr_ready); end
    n_vec++; if ({bus.fir_ce, bus.rd_valid, bus.irq} !== 3'b0) begin
      n_err++; $display("FAIL mid_outputs got %b exp 000", {bus.fir_ce, bus.rd_valid, bus.irq}); end
    q.delete();
    sw_prime = 0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    for (int i = 0; i < 3; i++) push(IW'(40 + 1000 * i), 1'b1);
    wait_idle("mid");
    n_vec++; if (bus.out_count !== 4'd1) begin n_err++; $display("FAIL mid_reprime got %0d exp 1", bus.out_count); end
    drain("mid");
  endtask
  initial begin
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
    bus.cfg_enable = 1'b0; bus.cfg_flush = 1'b0; bus.err_clr = 1'b0;
    test_reset();
    test_stream();
    test_flush();
    test_overflow();
    test_full_stall();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
endmodule
